// File: rtl/sw_pkg.sv
// Shared Smith-Waterman definitions: base encodings, CIGAR op codes,
// scoring constants and the CIGAR encoder FSM states.
package sw_pkg;

    // Base encodings on the aligned sequence buses
    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_T = 2'b01;
    localparam logic [1:0] BASE_G = 2'b10;
    localparam logic [1:0] BASE_C = 2'b11;

    // CIGAR operation codes as they appear on op_code
    typedef enum logic [1:0] {
        OP_M = 2'd0,
        OP_X = 2'd1,
        OP_I = 2'd2,
        OP_D = 2'd3
    } cigar_op_e;

    // Scoring constants, shared with the aligner core
    localparam int MATCH_SCORE    = 3;
    localparam int MISMATCH_SCORE = -1;
    localparam int GAP_SCORE      = -2;

    // CIGAR encoder control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_FIN  = 2'd3
    } enc_state_e;

    // Score contribution of one aligned position of the given class
    function automatic int op_score(cigar_op_e op);
        case (op)
            OP_M:    return MATCH_SCORE;
            OP_X:    return MISMATCH_SCORE;
            default: return GAP_SCORE;
        endcase
    endfunction

endpackage

// File: rtl/sw_cigar_encoder_if.sv
// Result-in / CIGAR-out bundle of the CIGAR encoder.
// master = aligner/host side, slave = encoder side.
interface sw_cigar_encoder_if #(
    parameter int ALIGN_LEN  = 25,
    parameter int BASE_WIDTH = 2,
    parameter int RUN_W      = 3,
    parameter int SCORE_W    = 16
);
    // Result input stream
    logic                            in_valid;
    logic                            in_ready;
    logic [ALIGN_LEN*BASE_WIDTH-1:0] aligned_ref_seq;
    logic [ALIGN_LEN*BASE_WIDTH-1:0] aligned_query_seq;
    logic [ALIGN_LEN-1:0]            ref_gap_mask;
    logic [ALIGN_LEN-1:0]            query_gap_mask;
    logic [7:0]                      alignment_length;

    // CIGAR op output stream
    logic                            op_valid;
    logic                            op_ready;
    logic [1:0]                      op_code;
    logic [RUN_W-1:0]                op_len;
    logic                            op_last;
    logic [SCORE_W-1:0]              score;

    // Status
    logic                            done;
    logic                            err;

    modport master (
        output in_valid, aligned_ref_seq, aligned_query_seq,
               ref_gap_mask, query_gap_mask, alignment_length, op_ready,
        input  in_ready, op_valid, op_code, op_len, op_last, score, done, err
    );

    modport slave (
        input  in_valid, aligned_ref_seq, aligned_query_seq,
               ref_gap_mask, query_gap_mask, alignment_length, op_ready,
        output in_ready, op_valid, op_code, op_len, op_last, score, done, err
    );

endinterface

// File: rtl/sw_cigar_classify.sv
// Combinational classifier for one aligned position: M/X/I/D plus a flag
// for the illegal case where both sequences claim a gap.
module sw_cigar_classify
    import sw_pkg::*;
#(
    parameter int BASE_WIDTH = 2
) (
    input  logic [BASE_WIDTH-1:0] ref_base,
    input  logic [BASE_WIDTH-1:0] query_base,
    input  logic                  ref_gap,
    input  logic                  query_gap,
    output cigar_op_e             op_class,
    output logic                  both_gap
);

    // Query gap wins over ref gap, so a double gap degrades to D
    always_comb begin
        both_gap = ref_gap & query_gap;
        if (query_gap) begin
            op_class = OP_D;
        end else if (ref_gap) begin
            op_class = OP_I;
        end else if (ref_base == query_base) begin
            op_class = OP_M;
        end else begin
            op_class = OP_X;
        end
    end

endmodule

// File: rtl/sw_cigar_encoder.sv
// Streaming CIGAR encoder: walks a captured alignment from its start
// (highest index) down to index 0 and emits run-length ops.
// Optional score accumulator is compiled in when SW_CIGAR_SCORE_EN is defined;
// otherwise score is tied to 0.
module sw_cigar_encoder
    import sw_pkg::*;
#(
    parameter int ALIGN_LEN  = 25,
    parameter int BASE_WIDTH = 2,
    parameter int RUN_W      = 3,
    parameter int SCORE_W    = 16
) (
    input logic              clk,
    input logic              rst_n,
    sw_cigar_encoder_if.slave bus
);

    localparam int               IDX_W     = (ALIGN_LEN > 1) ? $clog2(ALIGN_LEN) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX   = '1;
    localparam logic [7:0]       ALIGN_MAX = 8'(ALIGN_LEN);

    enc_state_e                      state_reg, state_next;
    logic [ALIGN_LEN*BASE_WIDTH-1:0] ref_reg;
    logic [ALIGN_LEN*BASE_WIDTH-1:0] qry_reg;
    logic [ALIGN_LEN-1:0]            rgap_reg;
    logic [ALIGN_LEN-1:0]            qgap_reg;
    logic [IDX_W-1:0]                idx_reg, idx_next;
    cigar_op_e                       run_class_reg, run_class_next;
    logic [RUN_W-1:0]                run_len_reg, run_len_next;
    logic                            last_reg, last_next;
    logic                            err_reg, err_next;
    logic                            capture;
    logic                            consume;
    logic [7:0]                      len_clamped;

    logic [BASE_WIDTH-1:0]           cur_ref;
    logic [BASE_WIDTH-1:0]           cur_qry;
    cigar_op_e                       cur_class;
    logic                            cur_both;

    assign len_clamped = (bus.alignment_length > ALIGN_MAX) ? ALIGN_MAX : bus.alignment_length;
    assign cur_ref     = ref_reg[idx_reg*BASE_WIDTH +: BASE_WIDTH];
    assign cur_qry     = qry_reg[idx_reg*BASE_WIDTH +: BASE_WIDTH];

    sw_cigar_classify #(
        .BASE_WIDTH (BASE_WIDTH)
    ) u_classify (
        .ref_base   (cur_ref),
        .query_base (cur_qry),
        .ref_gap    (rgap_reg[idx_reg]),
        .query_gap  (qgap_reg[idx_reg]),
        .op_class   (cur_class),
        .both_gap   (cur_both)
    );

    // Next-state logic: accept, scan/extend the current run, emit, finish
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        run_class_next = run_class_reg;
        run_len_next   = run_len_reg;
        last_next      = last_reg;
        err_next       = err_reg;
        capture        = 1'b0;
        consume        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    capture        = 1'b1;
                    err_next       = 1'b0;
                    run_len_next   = '0;
                    run_class_next = OP_M;
                    last_next      = 1'b0;
                    idx_next       = IDX_W'(len_clamped - 8'd1);
                    state_next     = (len_clamped == 8'd0) ? ST_FIN : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (run_len_reg == '0) begin
                    run_class_next = cur_class;
                    run_len_next   = RUN_W'(1);
                    consume        = 1'b1;
                end else if (cur_class == run_class_reg && run_len_reg != RUN_MAX) begin
                    run_len_next   = run_len_reg + RUN_W'(1);
                    consume        = 1'b1;
                end else begin
                    // Position idx stays unconsumed; it opens the next run
                    last_next  = 1'b0;
                    state_next = ST_EMIT;
                end
                if (consume) begin
                    if (cur_both) begin
                        err_next = 1'b1;
                    end
                    if (idx_reg == '0) begin
                        last_next  = 1'b1;
                        state_next = ST_EMIT;
                    end else begin
                        idx_next = idx_reg - IDX_W'(1);
                    end
                end
            end
            ST_EMIT: begin
                if (bus.op_ready) begin
                    if (last_reg) begin
                        state_next = ST_FIN;
                    end else begin
                        run_len_next = '0;
                        state_next   = ST_SCAN;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Control and captured-result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            run_class_reg <= OP_M;
            run_len_reg   <= '0;
            last_reg      <= 1'b0;
            err_reg       <= 1'b0;
            ref_reg       <= '0;
            qry_reg       <= '0;
            rgap_reg      <= '0;
            qgap_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            run_class_reg <= run_class_next;
            run_len_reg   <= run_len_next;
            last_reg      <= last_next;
            err_reg       <= err_next;
            if (capture) begin
                ref_reg  <= bus.aligned_ref_seq;
                qry_reg  <= bus.aligned_query_seq;
                rgap_reg <= bus.ref_gap_mask;
                qgap_reg <= bus.query_gap_mask;
            end
        end
    end

`ifdef SW_CIGAR_SCORE_EN
    logic signed [SCORE_W-1:0] score_reg;

    // Score accumulates once per consumed position; cleared on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_reg <= '0;
        end else if (capture) begin
            score_reg <= '0;
        end else if (consume) begin
            score_reg <= score_reg + SCORE_W'(op_score(cur_class));
        end
    end

    assign bus.score = score_reg;
`else
    assign bus.score = '0;
`endif

    assign bus.in_ready = (state_reg == ST_IDLE);
    assign bus.op_valid = (state_reg == ST_EMIT);
    assign bus.op_code  = (state_reg == ST_EMIT) ? 2'(run_class_reg) : 2'b00;
    assign bus.op_len   = (state_reg == ST_EMIT) ? run_len_reg : '0;
    assign bus.op_last  = (state_reg == ST_EMIT) ? last_reg : 1'b0;
    assign bus.done     = (state_reg == ST_FIN);
    assign bus.err      = err_reg;

endmodule

// File: tb/tb_sw_cigar_encoder.sv
// Directed bench for sw_cigar_encoder: identical bases, mixed classes,
// run cap, backpressure, zero length, double-gap error, mid-op reset.
module tb_sw_cigar_encoder;

    localparam int AL = 25;
    localparam int BW = 2;
    localparam int RW = 3;
    localparam int SW = 16;

    localparam int C_M = 0;
    localparam int C_X = 1;
    localparam int C_I = 2;
    localparam int C_D = 3;

    localparam logic [1:0] A = 2'b00;
    localparam logic [1:0] T = 2'b01;
    localparam logic [1:0] G = 2'b10;
    localparam logic [1:0] C = 2'b11;

    typedef struct {
        int code;
        int len;
    } exp_op_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_op_t exp_q[$];

    sw_cigar_encoder_if #(.ALIGN_LEN(AL), .BASE_WIDTH(BW), .RUN_W(RW), .SCORE_W(SW)) bus ();

    sw_cigar_encoder #(
        .ALIGN_LEN  (AL),
        .BASE_WIDTH (BW),
        .RUN_W      (RW),
        .SCORE_W    (SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic clear_inputs();
        bus.aligned_ref_seq   = '0;
        bus.aligned_query_seq = '0;
        bus.ref_gap_mask      = '0;
        bus.query_gap_mask    = '0;
        bus.alignment_length  = '0;
        exp_q.delete();
    endtask

    // k counts from the alignment start; index 0 is the alignment end
    task automatic set_pos(input int len, input int k, input logic [1:0] r, input logic [1:0] q,
                           input logic rg, input logic qg);
        int i;
        i = len - 1 - k;
        bus.aligned_ref_seq[i*BW +: BW]   = r;
        bus.aligned_query_seq[i*BW +: BW] = q;
        bus.ref_gap_mask[i]               = rg;
        bus.query_gap_mask[i]             = qg;
    endtask

    task automatic push_op(input int code, input int len);
        exp_op_t e;
        e.code = code;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    // A/A, C/C, G/T, A/-, C/-, -/G  ->  M2 X1 D2 I1
    task automatic load_mixed();
        clear_inputs();
        set_pos(6, 0, A, A, 1'b0, 1'b0);
        set_pos(6, 1, C, C, 1'b0, 1'b0);
        set_pos(6, 2, G, T, 1'b0, 1'b0);
        set_pos(6, 3, A, A, 1'b0, 1'b1);
        set_pos(6, 4, C, C, 1'b0, 1'b1);
        set_pos(6, 5, G, G, 1'b1, 1'b0);
        push_op(C_M, 2);
        push_op(C_X, 1);
        push_op(C_D, 2);
        push_op(C_I, 1);
    endtask

    task automatic load_identical();
        clear_inputs();
        set_pos(4, 0, A, A, 1'b0, 1'b0);
        set_pos(4, 1, C, C, 1'b0, 1'b0);
        set_pos(4, 2, G, G, 1'b0, 1'b0);
        set_pos(4, 3, T, T, 1'b0, 1'b0);
        push_op(C_M, 4);
    endtask

    // Present one result, drain ops against exp_q with `stall` cycles of
    // op_ready low at each op, and check done timing, err and score.
    task automatic run_result(input string name, input int len, input int stall,
                              input int exp_done_cyc, input int exp_score, input int exp_err);
        int  cyc;
        int  n_ops;
        int  stall_cnt;
        int  exp_last;
        bit  got_done;
        @(negedge clk);
        check_eq({name, ".in_ready"}, int'(bus.in_ready), 1);
        bus.alignment_length = 8'(len);
        bus.in_valid         = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc       = 1;
        n_ops     = 0;
        stall_cnt = 0;
        got_done  = 1'b0;
        check_eq({name, ".err_after_accept"}, int'(bus.err), 0);
        while (!got_done && cyc < 300) begin
            if (bus.done) begin
                got_done = 1'b1;
                check_eq({name, ".done_cycle"}, cyc, exp_done_cyc);
                check_eq({name, ".op_count"}, n_ops, exp_q.size());
                check_eq({name, ".err"}, int'(bus.err), exp_err);
            end else if (bus.op_valid) begin
                if (n_ops >= exp_q.size()) begin
                    check_eq({name, ".extra_op"}, n_ops, exp_q.size() - 1);
                    bus.op_ready = 1'b1;
                    n_ops++;
                end else begin
                    exp_last = (n_ops == exp_q.size() - 1) ? 1 : 0;
                    $display("op %0d of %s: code=%0d len=%0d last=%0d", n_ops, name,
                             bus.op_code, bus.op_len, bus.op_last);
                    check_eq($sformatf("%s.op%0d.code", name, n_ops), int'(bus.op_code), exp_q[n_ops].code);
                    check_eq($sformatf("%s.op%0d.len", name, n_ops), int'(bus.op_len), exp_q[n_ops].len);
                    check_eq($sformatf("%s.op%0d.last", name, n_ops), int'(bus.op_last), exp_last);
                    if (exp_last == 1) begin
`ifdef SW_CIGAR_SCORE_EN
                        check_eq({name, ".score"}, int'($signed(bus.score)), exp_score);
`else
                        check_eq({name, ".score"}, int'($signed(bus.score)), 0 * exp_score);
`endif
                    end
                    if (stall_cnt < stall) begin
                        bus.op_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        bus.op_ready = 1'b1;
                        stall_cnt    = 0;
                        n_ops++;
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (!got_done) begin
            check_eq({name, ".done_timeout"}, 0, 1);
        end
        bus.op_ready = 1'b1;
    endtask

    initial begin
        n_checks             = 0;
        n_errors             = 0;
        rst_n                = 1'b0;
        bus.in_valid         = 1'b0;
        bus.op_ready         = 1'b1;
        clear_inputs();

        repeat (2) @(negedge clk);
        check_eq("reset.in_ready", int'(bus.in_ready), 1);
        check_eq("reset.op_valid", int'(bus.op_valid), 0);
        check_eq("reset.done", int'(bus.done), 0);
        check_eq("reset.err", int'(bus.err), 0);
        check_eq("reset.op_len", int'(bus.op_len), 0);
        check_eq("reset.score", int'(bus.score), 0);
        rst_n = 1'b1;

        load_identical();
        run_result("identical", 4, 0, 6, 12, 0);

        load_mixed();
        run_result("mixed", 6, 0, 14, -1, 0);

        load_mixed();
        run_result("backpressure", 6, 5, 34, -1, 0);

        clear_inputs();
        for (int k = 0; k < 10; k++) set_pos(10, k, G, G, 1'b0, 1'b0);
        push_op(C_M, 7);
        push_op(C_M, 3);
        run_result("run_cap", 10, 0, 14, 30, 0);

        clear_inputs();
        run_result("zero_len", 0, 0, 1, 0, 0);

        clear_inputs();
        set_pos(3, 0, A, A, 1'b0, 1'b0);
        set_pos(3, 1, C, G, 1'b1, 1'b1);
        set_pos(3, 2, T, T, 1'b0, 1'b0);
        push_op(C_M, 1);
        push_op(C_D, 1);
        push_op(C_M, 1);
        run_result("both_gap", 3, 0, 9, 4, 1);
        @(negedge clk);
        check_eq("both_gap.err_sticky", int'(bus.err), 1);

        load_identical();
        run_result("after_err", 4, 0, 6, 12, 0);

        // Reset while an op is held in EMIT
        load_mixed();
        bus.op_ready = 1'b0;
        @(negedge clk);
        bus.alignment_length = 8'd6;
        bus.in_valid         = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int c = 0; c < 20 && !bus.op_valid; c++) @(negedge clk);
        check_eq("midrst.pre_valid", int'(bus.op_valid), 1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst.op_valid", int'(bus.op_valid), 0);
        check_eq("midrst.in_ready", int'(bus.in_ready), 1);
        check_eq("midrst.op_len", int'(bus.op_len), 0);
        check_eq("midrst.op_code", int'(bus.op_code), 0);
        check_eq("midrst.score", int'(bus.score), 0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.op_ready = 1'b1;

        load_identical();
        run_result("post_reset", 4, 0, 6, 12, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
